// File: rtl/sync_fifo_rd_pkg.sv
// Shared types and constants for the sync_fifo packet reader.
// rd_state_e is also exported on the reader's state_dbg port.
package sync_fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  // Cycles from an accepted FIFO read to its word appearing on fifo_data_out.
  localparam int RD_LAT = 1;

  // Words that may be buffered or in flight at once: enough to cover the
  // read latency plus the word currently presented downstream.
  localparam int BUF_DEPTH = RD_LAT + 1;

  // Width of a counter that must hold the values 0..pkt_len.
  function automatic int idx_width(input int pkt_len);
    return $clog2(pkt_len + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_rd_skid.sv
// Two-entry output buffer for the packet reader.
//
// Handshake: a word moves across the out_* interface on a rising edge where
// out_valid && out_ready are both high. While out_valid is high and out_ready
// is low, out_data is held stable. out_valid never depends on out_ready.
//
// in_valid marks the cycle in which fifo_data_out carries a freshly read
// word. When the buffer is empty, that word is presented directly on out_*
// in the same cycle, so the FIFO's read latency costs no throughput. A word
// that is not taken is captured so it stays stable for the next cycle. The
// caller never presents a word while the buffer is full.
module sync_fifo_rd_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  pop;
  logic                  pop_stored;
  logic                  take;
  logic [1:0]            keep;

  // Stored words go out first; the incoming word bypasses only when empty.
  assign out_valid  = (occ != 2'd0) || in_valid;
  assign out_data   = (occ != 2'd0) ? entry0 : (in_valid ? in_data : '0);
  assign pop        = out_valid && out_ready;
  assign pop_stored = pop && (occ != 2'd0);
  assign take       = in_valid && !(pop && (occ == 2'd0));
  assign keep       = occ - {1'b0, pop_stored};

  // Shift the queue on a pop of a stored word, then append the incoming word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= 2'd0;
    end else begin
      if (pop_stored) begin
        entry0 <= entry1;
      end
      if (take) begin
        if (keep == 2'd0) begin
          entry0 <= in_data;
        end else begin
          entry1 <= in_data;
        end
      end
      occ <= keep + {1'b0, take};
    end
  end

endmodule

// File: rtl/sync_fifo_pkt_reader.sv
// Read-side engine for sync_fifo: drains fixed-length packets of PKT_LEN
// words onto a valid/ready stream, starting a packet only once the FIFO is
// past its almost-empty threshold.
//
// Optional build macro: FIFO_RD_STATS_EN adds the free-running word_cnt and
// stall_cnt outputs. Without it those ports and counters do not exist.
//
// state_dbg exposes the FSM state (rd_state_e encoding) for observation.
module sync_fifo_pkt_reader
  import sync_fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_pro_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [1:0]            state_dbg,
  output logic [CNT_W-1:0]      pkt_cnt
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           word_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int IDX_W = idx_width(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] PKT_WORDS = IDX_W'(PKT_LEN);

  rd_state_e        state;
  logic [IDX_W-1:0] rd_cnt;
  logic [IDX_W-1:0] word_idx;
  logic             inflight;
  logic [1:0]       occ;
  logic [1:0]       outstanding;
  logic             rd_acc;
  logic             beat;
  logic             last_beat;

  sync_fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight),
    .in_data   (fifo_data_out),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .occ       (occ)
  );

  // Words already owned by the reader: buffered plus the one being returned.
  assign outstanding = occ + {1'b0, inflight};

  assign fifo_rd_en = (state == STREAM) && !fifo_empty &&
                      (int'(outstanding) < BUF_DEPTH) &&
                      (rd_cnt < PKT_WORDS);
  assign rd_acc     = fifo_rd_en && !fifo_empty;
  assign beat       = m_valid && m_ready;
  assign m_last     = m_valid && (word_idx == LAST_IDX);
  assign last_beat  = beat && m_last;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  // Packet FSM with its read/beat counters and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      word_idx <= '0;
      inflight <= 1'b0;
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      inflight <= rd_acc;
      pkt_done <= last_beat;
      if (beat) begin
        word_idx <= m_last ? '0 : word_idx + 1'b1;
      end
      if (last_beat) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (en && !fifo_pro_empty) begin
            state  <= STREAM;
            rd_cnt <= '0;
          end
        end
        STREAM: begin
          if (rd_acc) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_beat) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Free-running delivery and back-pressure counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (beat) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (m_valid && !m_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
